// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix ALU datapath and its stream loader.
package matrix_pkg;

  localparam int unsigned WIDTH_BIT = 2;
  localparam int unsigned WIDTH     = 2 ** WIDTH_BIT;
  localparam int unsigned ELEM_W    = 32;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_MOD  = 3'd4;
  localparam logic [2:0] OP_MMUL = 3'd5;

  typedef logic signed [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0] matrix_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StHold
  } loader_state_e;

endpackage

// File: rtl/mat_frame_reg.sv
// WIDTH x WIDTH element register bank written one element at a time by linear
// row-major index, cleared asynchronously.
module mat_frame_reg #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ELEM_W = 32,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic                                       i_we,
  input  logic [IDX_W-1:0]                           i_idx,
  input  logic [ELEM_W-1:0]                          i_data,
  output logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]    o_mat
);

  logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0] r_mat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mat <= '0;
    end else if (i_we) begin
      for (int r = 0; r < int'(WIDTH); r++) begin
        for (int c = 0; c < int'(WIDTH); c++) begin
          if (i_idx == IDX_W'(r * int'(WIDTH) + c)) r_mat[r][c] <= i_data;
        end
      end
    end
  end

  assign o_mat = r_mat;

endmodule

// File: rtl/matrix_stream_loader.sv
// Assembles operand matrices A and B plus an op code from a serial element stream
// and holds them as one frame for the matrix ALU. Optional: LOADER_DIVZERO_CHECK_EN.
module matrix_stream_loader #(
  parameter int unsigned WIDTH_BIT = matrix_pkg::WIDTH_BIT,
  parameter int unsigned WIDTH     = 2 ** WIDTH_BIT,
  parameter int unsigned ELEM_W    = matrix_pkg::ELEM_W
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [ELEM_W-1:0]                       in_data,
  input  logic [2:0]                              in_op,
  output logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0] mat_a,
  output logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0] mat_b,
  output logic [2:0]                              sel_out,
  output logic                                    op_valid,
  input  logic                                    op_ack,
  output logic                                    bad_op
`ifdef LOADER_DIVZERO_CHECK_EN
  ,
  output logic                                    err_divzero
`endif
);

  import matrix_pkg::*;

  localparam int unsigned NELEM = WIDTH * WIDTH;
  // Keep at least one counter bit so the WIDTH=1 build still elaborates.
  localparam int unsigned CNT_W = (WIDTH_BIT == 0) ? 1 : 2 * WIDTH_BIT;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NELEM - 1);

  loader_state_e    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic             r_op_valid;
  logic             r_bad_op;

  logic w_fire;
  logic w_last;
  logic w_we_a;
  logic w_we_b;

  assign in_ready = rst_n && (r_state != StHold);
  assign w_fire   = in_valid && in_ready;
  assign w_last   = (r_cnt == LAST_IDX);
  assign w_we_a   = w_fire && ((r_state == StIdle) || (r_state == StLoadA));
  assign w_we_b   = w_fire && (r_state == StLoadB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_sel      <= '0;
      r_op_valid <= 1'b0;
      r_bad_op   <= 1'b0;
    end else begin
      r_bad_op <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_fire) begin
            r_sel <= in_op;
            if (NELEM == 1) begin
              r_cnt   <= '0;
              r_state <= StLoadB;
            end else begin
              r_cnt   <= CNT_W'(1);
              r_state <= StLoadA;
            end
          end
        end
        StLoadA: begin
          if (w_fire) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= StLoadB;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StLoadB: begin
          if (w_fire) begin
            if (w_last) begin
              r_cnt <= '0;
              if (r_sel > OP_MMUL) begin
                r_state  <= StIdle;
                r_bad_op <= 1'b1;
              end else begin
                r_state    <= StHold;
                r_op_valid <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StHold: begin
          if (op_ack) begin
            r_state    <= StIdle;
            r_op_valid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  mat_frame_reg #(
    .WIDTH  (WIDTH),
    .ELEM_W (ELEM_W),
    .IDX_W  (CNT_W)
  ) u_frame_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_we    (w_we_a),
    .i_idx   (r_cnt),
    .i_data  (in_data),
    .o_mat   (mat_a)
  );

  mat_frame_reg #(
    .WIDTH  (WIDTH),
    .ELEM_W (ELEM_W),
    .IDX_W  (CNT_W)
  ) u_frame_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_we    (w_we_b),
    .i_idx   (r_cnt),
    .i_data  (in_data),
    .o_mat   (mat_b)
  );

  assign sel_out  = r_sel;
  assign op_valid = r_op_valid;
  assign bad_op   = r_bad_op;

`ifdef LOADER_DIVZERO_CHECK_EN
  logic r_divzero;
  logic w_to_idle;

  assign w_to_idle = ((r_state == StHold) && op_ack) ||
                     (w_we_b && w_last && (r_sel > OP_MMUL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divzero <= 1'b0;
    end else if (w_to_idle) begin
      r_divzero <= 1'b0;
    end else if (w_we_b && (in_data == '0) && ((r_sel == OP_DIV) || (r_sel == OP_MOD))) begin
      r_divzero <= 1'b1;
    end
  end

  assign err_divzero = r_divzero && r_op_valid;
`endif

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench for matrix_stream_loader at WIDTH=2: a driver pushes expected
// frames, a monitor pops and checks them when the loader presents a frame or bad_op.
module tb_matrix_stream_loader;

  localparam int W = 2;
  localparam int N = W * W;

  typedef logic [0:W-1][0:W-1][31:0] mat_t;
  typedef struct packed {
    mat_t       a;
    mat_t       b;
    logic [2:0] op;
    logic       bad;
    logic       dz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [31:0] in_data;
  logic [2:0] in_op;
  mat_t       mat_a;
  mat_t       mat_b;
  logic [2:0] sel_out;
  logic       op_valid;
  logic       op_ack;
  logic       bad_op;
`ifdef LOADER_DIVZERO_CHECK_EN
  logic       err_divzero;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  matrix_stream_loader #(
    .WIDTH_BIT (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_op    (in_op),
    .mat_a    (mat_a),
    .mat_b    (mat_b),
    .sel_out  (sel_out),
    .op_valid (op_valid),
    .op_ack   (op_ack),
    .bad_op   (bad_op)
`ifdef LOADER_DIVZERO_CHECK_EN
    ,
    .err_divzero (err_divzero)
`endif
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: element i of the stream lands at row i/W, col i%W of A, then B.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] el [8]);
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      e.a[i / W][i % W] = el[i];
      e.b[i / W][i % W] = el[N + i];
      if (el[N + i] == 32'd0 && (op == 3'd3 || op == 3'd4)) e.dz = 1'b1;
    end
    e.op  = op;
    e.bad = (op >= 3'd6);
    return e;
  endfunction

  task automatic send_elem(input logic [31:0] d, input logic [2:0] op, input int bub);
    bit acc = 1'b0;
    int guard = 0;
    in_data = d;
    in_op   = op;
    while (!acc) begin
      in_valid = ($urandom_range(99) >= bub);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 200) begin
        chk1("accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [2:0] op, input logic [31:0] el [8], input bit push,
                            input int n_send, input int bub, input int gap_after);
    exp_t e;
    e = model(op, el);
    if (push) q.push_back(e);
    for (int i = 0; i < n_send; i++) begin
      // in_op only matters on the first element; garble it afterwards.
      send_elem(el[i], (i == 0) ? op : 3'($urandom_range(7)), bub);
      if (i + 1 == gap_after) repeat (10) begin
        @(posedge clk);
        #1;
      end
    end
    if (push && n_send == 2 * N) begin
      if (e.bad) chk1("bad_pulse_latency", bad_op, 1'b1);
      else       chk1("valid_latency", op_valid, 1'b1);
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((q.size() != 0 || op_valid || op_ack) && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk1("drain", (g < 500), 1'b1);
  endtask

  // Monitor / consumer
  bit   prev_v;
  bit   prev_b;
  int   hold_left;
  logic [258:0] snap;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v    = 1'b0;
      prev_b    = 1'b0;
      hold_left = 0;
      op_ack    = 1'b0;
    end else begin
      if (op_ack) begin
        chk1("ack_drops_valid", op_valid, 1'b0);
        chk1("ready_after_ack", in_ready, 1'b1);
        chkw("retain_after_ack", 512'({mat_a, mat_b, sel_out}), 512'(snap));
        op_ack = 1'b0;
      end else if (op_valid) begin
        if (!prev_v) begin
          if (q.size() == 0) begin
            chk1("unexpected_frame", 1'b1, 1'b0);
            e = '0;
          end else begin
            e = q.pop_front();
          end
          chk1("frame_not_bad", e.bad, 1'b0);
          chkw("mat_a", 512'(mat_a), 512'(e.a));
          chkw("mat_b", 512'(mat_b), 512'(e.b));
          chkw("sel_out", 512'(sel_out), 512'(e.op));
`ifdef LOADER_DIVZERO_CHECK_EN
          chk1("err_divzero", err_divzero, e.dz);
`endif
          snap      = {mat_a, mat_b, sel_out};
          hold_left = $urandom_range(5);
        end else begin
          chkw("hold_stable", 512'({mat_a, mat_b, sel_out}), 512'(snap));
        end
        chk1("hold_not_ready", in_ready, 1'b0);
        chk1("hold_no_bad", bad_op, 1'b0);
        if (hold_left == 0) op_ack = 1'b1;
        else hold_left--;
      end
`ifdef LOADER_DIVZERO_CHECK_EN
      if (!op_valid) chk1("divzero_masked", err_divzero, 1'b0);
`endif
      if (bad_op) begin
        chk1("bad_one_cycle", prev_b, 1'b0);
        chk1("bad_back_idle", in_ready, 1'b1);
        if (q.size() == 0) begin
          chk1("unexpected_bad", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          chk1("bad_expected", e.bad, 1'b1);
        end
      end
      prev_v = op_valid;
      prev_b = bad_op;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] el [8];
    logic [31:0] zb [8];
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_op    = '0;
    op_ack   = 1'b0;
    #1;
    chk1("rst_ready", in_ready, 1'b0);
    chk1("rst_valid", op_valid, 1'b0);
    chk1("rst_bad", bad_op, 1'b0);
    chkw("rst_mats", 512'({mat_a, mat_b, sel_out}), 512'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("idle_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) el[i] = 32'(i + 1);
    send_frame(3'd0, el, 1'b1, 8, 0, -1);
    wait_drain();
    send_frame(3'd5, el, 1'b1, 8, 50, 4);
    wait_drain();
    send_frame(3'd6, el, 1'b1, 8, 0, -1);
    wait_drain();
    chk1("idle_after_bad", in_ready, 1'b1);

    for (int i = 0; i < 4; i++) zb[i] = $urandom;
    zb[4] = 32'd4; zb[5] = 32'd0; zb[6] = 32'd2; zb[7] = 32'd1;
    send_frame(3'd3, zb, 1'b1, 8, 0, -1);
    send_frame(3'd0, zb, 1'b1, 8, 0, -1);
    wait_drain();

    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < 8; i++) el[i] = ($urandom_range(7) == 0) ? 32'd0 : 32'($urandom);
      send_frame(3'($urandom_range(7)), el, 1'b1, 8, $urandom_range(60), -1);
    end
    wait_drain();

    for (int i = 0; i < 8; i++) el[i] = 32'($urandom);
    send_frame(3'd1, el, 1'b0, 5, 0, -1);
    rst_n = 1'b0;
    #1;
    chkw("midreset_mats", 512'({mat_a, mat_b, sel_out}), 512'(0));
    chk1("midreset_valid", op_valid, 1'b0);
    chk1("midreset_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) el[i] = 32'(100 + i);
    send_frame(3'd2, el, 1'b1, 8, 20, -1);
    wait_drain();

    chk1("queue_empty", (q.size() == 0), 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_stream_loader.md
Name: matrix_stream_loader

Overview:
- Upstream feeder for the matrix ALU.
- Accepts a serial stream of signed 32-bit elements over a valid/ready handshake.
- Assembles operand matrices A and B row-major and latches the operation code.
- Presents a, b and sel to the ALU as one stable frame, held until the consumer acknowledges it.

Parameters:
- WIDTH_BIT, 2, log2 of matrix dimension.
- WIDTH, 2**WIDTH_BIT, matrix dimension; ALU instantiated with the same value.
- ELEM_W, 32, element width in bits (fixed at 32 for ALU compatibility).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  producer has an element on in_data.
- in_ready  output  1  loader can accept an element this cycle.
- in_data  input  ELEM_W  signed element, row-major, A then B.
- in_op  input  3  operation code, sampled only with the first element of a frame.
- mat_a  output  [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]  signed operand A to the ALU.
- mat_b  output  [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]  signed operand B to the ALU.
- sel_out  output  3  operation code to the ALU (0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 matrix_mul).
- op_valid  output  1  frame complete and stable.
- op_ack  input  1  consumer has captured the ALU result.
- bad_op  output  1  one-cycle pulse when a frame carried op 6 or 7.

Behaviour:
- Transfer occurs on a clock edge where in_valid && in_ready.
- Reset (rst_n low, any time, including mid-frame):
  - state IDLE, element counter 0.
  - mat_a, mat_b all zero; sel_out 0.
  - op_valid 0, bad_op 0, in_ready 0 while rst_n low.
  - A partially loaded frame is discarded.
- States:
  - IDLE: in_ready 1. On transfer, write A[0][0], latch in_op into sel_out, counter to 1, go to LOAD_A. With WIDTH=1, go directly to LOAD_B.
  - LOAD_A: in_ready 1. Each transfer writes A[cnt/WIDTH][cnt%WIDTH]. On the transfer at cnt = WIDTH*WIDTH-1, reset counter to 0 and go to LOAD_B.
  - LOAD_B: in_ready 1. Same element mapping into B. On the last transfer:
    - op ≤ 5: go to HOLD.
    - op 6 or 7: go to IDLE and pulse bad_op for exactly one cycle.
  - HOLD: in_ready 0, op_valid 1. mat_a, mat_b and sel_out frozen. When op_ack is high, go to IDLE next cycle and deassert op_valid.
- Latency: op_valid rises on the clock edge that accepts the last B element, so the frame is visible in the following cycle. Minimum frame is 2*WIDTH*WIDTH accepted elements.
- Throughput:
  - in_ready is registered-state-based only; it does not depend combinationally on in_valid or op_ack.
  - One idle cycle minimum between frames: the ack cycle leaves HOLD, and IDLE accepts the next element the following cycle.
- op_ack outside HOLD is ignored.
- Stalls: in_valid low mid-frame leaves all state unchanged, with no timeout.
- After ack, mat_a/mat_b/sel_out keep their last values until overwritten by the next frame.
- Counter width is 2*WIDTH_BIT bits and wraps only under the explicit reset above; it never overflows silently.

Optional Feature:
- Macro: LOADER_DIVZERO_CHECK_EN.
- Defined:
  - Adds output err_divzero (1 bit).
  - A sticky per-frame flag is set when any B element equal to 0 is accepted while the latched op is 3 or 4.
  - err_divzero equals the flag while op_valid is 1, and is 0 otherwise.
  - The flag clears on entry to IDLE and on reset.
  - The frame is still presented normally.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package matrix_pkg holds:
  - WIDTH_BIT, WIDTH, ELEM_W.
  - op-code constants OP_ADD..OP_MMUL (0..5).
  - a typedef for the packed signed matrix type.
  - the loader state enum.
- One natural sub-module, mat_frame_reg: a WIDTH×WIDTH register bank with write-enable and linear index, asynchronous active-low clear. Instantiated twice (A and B).

Test Plan (WIDTH_BIT=1, WIDTH=2):
- Basic frame: in_op=0, stream 1,2,3,4,5,6,7,8 with continuous valid. Required: op_valid high the cycle after the 8th element; mat_a={{1,2},{3,4}}, mat_b={{5,6},{7,8}}, sel_out=0; in_ready 0 in HOLD.
- Hold and ack: keep op_ack low 5 cycles. Required: outputs stable and in_valid pulses ignored. Assert op_ack → op_valid 0 next cycle and in_ready 1.
- Bubbles: same frame with in_valid toggled every other cycle, plus a 10-cycle gap after element 4. Required: identical matrices and sel_out=5 when in_op=5.
- Bad op: in_op=6 with a full 8-element frame. Required: op_valid never asserts, bad_op high exactly one cycle, state IDLE afterwards.
- Reset mid-frame: drop rst_n after 5 elements. Required: immediate zero outputs and op_valid 0. A fresh 8-element frame then loads correctly.
- Div-zero (macro defined): in_op=3, B={{4,0},{2,1}}. Required: err_divzero 1 with op_valid. A following frame with op=0 and the same B gives err_divzero 0.
